// File: rtl/hsv_core_pkg.sv
// Core-wide types shared by the ALU and its issue arbiter.
package hsv_core_pkg;

    localparam int ALU_N_REQ     = 2;
    localparam int ALU_TAG_DEPTH = 4;

    typedef logic [$clog2(ALU_N_REQ)-1:0] alu_req_id;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_t;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } alu_data_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
    } commit_data_t;

endpackage

// File: rtl/hsv_core_alu_id_fifo.sv
// Requester-ID FIFO: records issue order so in-order ALU results can be routed back.
module hsv_core_alu_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/hsv_core_alu_arbiter.sv
// Round-robin issue arbiter sharing one ALU between N_REQ requesters,
// with in-order result routing and flush forwarding.
module hsv_core_alu_arbiter
    import hsv_core_pkg::*;
#(
    parameter int N_REQ     = ALU_N_REQ,
    parameter int TAG_DEPTH = ALU_TAG_DEPTH
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  flush_req,
    output logic                  flush_ack,
    input  alu_data_t [N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    output alu_data_t             alu_data,
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic                  alu_flush_req,
    input  logic                  alu_flush_ack,
    input  commit_data_t          alu_commit_data,
    input  logic                  alu_out_valid,
    output logic                  alu_out_ready,
    output commit_data_t          rsp_data,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state;
    logic [IW-1:0] prio, grant, head, prio_next;
    logic [CW-1:0] count;
    logic          issue_ok, issue_fire, rsp_ok, rsp_fire;

    // Later candidates in the loop are closer to prio, so they overwrite earlier ones.
    always_comb begin
        grant = prio;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(prio) + k) % N_REQ])
                grant = IW'((int'(prio) + k) % N_REQ);
        end
    end

    assign prio_next = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;

    // Full is judged on the registered count; a same-cycle pop does not open a slot.
    assign issue_ok   = (state == RUN) && !flush_req && (count < CW'(TAG_DEPTH));
    assign alu_valid  = issue_ok && (|req_valid);
    assign alu_data   = req_data[grant];
    assign issue_fire = alu_valid && alu_ready;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = issue_ok && (|req_valid) && alu_ready;
    end

    assign rsp_ok        = (count != '0) && !flush_req;
    assign alu_out_ready = rsp_ok && rsp_ready[head];
    assign rsp_fire      = alu_out_valid && alu_out_ready;
    assign rsp_data      = alu_commit_data;
    assign alu_flush_req = flush_req;

    always_comb begin
        rsp_valid       = '0;
        rsp_valid[head] = alu_out_valid && rsp_ok;
    end

    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            state     <= RUN;
            prio      <= '0;
            flush_ack <= 1'b0;
        end else begin
            flush_ack <= flush_req && alu_flush_ack;
            case (state)
                RUN:     if (flush_req)  state <= FLUSH;
                FLUSH:   if (!flush_req) state <= RUN;
                default: state <= RUN;
            endcase
            if (flush_req)       prio <= '0;
            else if (issue_fire) prio <= prio_next;
        end
    end

    hsv_core_alu_id_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IW)
    ) u_id_fifo (
        .clk   (clk_core),
        .rst_n (rst_core),
        .clear (flush_req),
        .push  (issue_fire),
        .pop   (rsp_fire),
        .wdata (grant),
        .head  (head),
        .count (count)
    );

    // A result with no recorded issuer means the ALU and this block disagree on in-flight work.
    a_result_has_owner: assert property (
        @(posedge clk_core) disable iff (!rst_core)
        (alu_out_valid && !flush_req) |-> (count != '0)
    ) else $error("alu_out_valid with empty ID FIFO");

endmodule

// File: tb/tb_hsv_core_alu_arbiter.sv
// Scoreboard bench: directed issue vectors push expected results; a monitor checks routed responses.
module tb_hsv_core_alu_arbiter;
    import hsv_core_pkg::*;

    localparam int N = 2;

    logic                clk_core = 1'b0;
    logic                rst_core;
    logic                flush_req;
    logic                flush_ack;
    alu_data_t [N-1:0]   req_data;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    alu_data_t           alu_data;
    logic                alu_valid;
    logic                alu_ready;
    logic                alu_flush_req;
    logic                alu_flush_ack;
    commit_data_t        alu_commit_data;
    logic                alu_out_valid;
    logic                alu_out_ready;
    commit_data_t        rsp_data;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;

    typedef struct {
        int           id;
        commit_data_t d;
    } exp_t;

    exp_t      exp_q[$];
    alu_data_t alu_q[$];
    int        n_chk  = 0;
    int        n_fail = 0;
    int        seq[N];

    hsv_core_alu_arbiter dut (
        .clk_core        (clk_core),
        .rst_core        (rst_core),
        .flush_req       (flush_req),
        .flush_ack       (flush_ack),
        .req_data        (req_data),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .alu_data        (alu_data),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_flush_req   (alu_flush_req),
        .alu_flush_ack   (alu_flush_ack),
        .alu_commit_data (alu_commit_data),
        .alu_out_valid   (alu_out_valid),
        .alu_out_ready   (alu_out_ready),
        .rsp_data        (rsp_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready)
    );

    always #5 clk_core = ~clk_core;

    function automatic alu_data_t mk(input int i, input int s);
        alu_data_t x;
        x.op = ALU_ADD;
        x.a  = 32'(i * 1000 + s);
        x.b  = 32'h100;
        x.rd = 5'(i * 8 + s % 8);
        return x;
    endfunction

    function automatic commit_data_t alu_fn(input alu_data_t x);
        commit_data_t r;
        r.result = x.a + x.b;
        r.rd     = x.rd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One issue cycle: drive, check the grant at negedge, record the expected result.
    task automatic step(input logic [1:0] v, input logic [1:0] exp_rdy, input string nm);
        exp_t e;
        req_valid = v;
        for (int i = 0; i < N; i++) req_data[i] = mk(i, seq[i]);
        @(negedge clk_core);
        chk(nm, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            e.id = exp_rdy[1] ? 1 : 0;
            e.d  = alu_fn(mk(e.id, seq[e.id]));
            exp_q.push_back(e);
            seq[e.id]++;
        end
        @(posedge clk_core); #1;
    endtask

    task automatic drain(input string nm);
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk_core); #1;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    // ALU model: one-cycle latency, in order, cleared by flush or reset.
    initial begin
        logic      do_push, do_pop, fl, rst_seen;
        alu_data_t d;
        alu_out_valid   = 1'b0;
        alu_flush_ack   = 1'b0;
        alu_commit_data = '0;
        forever begin
            @(negedge clk_core);
            do_push  = alu_valid && alu_ready;
            do_pop   = alu_out_valid && alu_out_ready;
            fl       = alu_flush_req;
            rst_seen = !rst_core;
            d        = alu_data;
            @(posedge clk_core); #1;
            if (fl || rst_seen) alu_q.delete();
            else begin
                if (do_pop) void'(alu_q.pop_front());
                if (do_push) alu_q.push_back(d);
            end
            alu_flush_ack = fl;
            alu_out_valid = alu_q.size() > 0;
            if (alu_q.size() > 0) alu_commit_data = alu_fn(alu_q[0]);
        end
    end

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk_core) begin
        exp_t e;
        if (rst_core && (|(rsp_valid & rsp_ready))) begin
            chk("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(i), 32'(e.id));
                        chk("rsp_result", rsp_data.result, e.d.result);
                        chk("rsp_rd", 32'(rsp_data.rd), 32'(e.d.rd));
                    end
                end
            end
        end
    end

    initial begin
        rst_core  = 1'b0;
        flush_req = 1'b0;
        req_valid = '0;
        req_data  = '0;
        alu_ready = 1'b1;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) seq[i] = 0;

        @(negedge clk_core);
        chk("rst_flush_ack", 32'(flush_ack), 32'd0);
        chk("rst_alu_valid", 32'(alu_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_out_ready", 32'(alu_out_ready), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_count", 32'(dut.count), 32'd0);
        @(posedge clk_core); #1;
        rst_core = 1'b1;
        @(posedge clk_core); #1;

        // Contention: alternating grants
        step(2'b11, 2'b01, "rr_0");
        step(2'b11, 2'b10, "rr_1");
        step(2'b11, 2'b01, "rr_2");
        step(2'b11, 2'b10, "rr_3");
        drain("rr_drain");

        // Single requester, then switch
        step(2'b10, 2'b10, "single_0");
        step(2'b10, 2'b10, "single_1");
        step(2'b10, 2'b10, "single_2");
        step(2'b01, 2'b01, "single_sw");
        drain("single_drain");

        // FIFO full with responses stalled
        rsp_ready = 2'b00;
        step(2'b11, 2'b10, "full_i0");
        step(2'b11, 2'b01, "full_i1");
        step(2'b11, 2'b10, "full_i2");
        step(2'b11, 2'b01, "full_i3");
        chk("full_count", 32'(dut.count), 32'd4);
        step(2'b11, 2'b00, "full_stall");
        rsp_ready = 2'b10;
        step(2'b11, 2'b00, "full_pop_noissue");
        rsp_ready = 2'b00;
        chk("full_count_pop", 32'(dut.count), 32'd3);
        step(2'b11, 2'b10, "full_slot");
        step(2'b11, 2'b00, "full_again");

        // Steady push+pop at count 3 across pointer wrap
        rsp_ready = 2'b11;
        step(2'b00, 2'b00, "pp_pop");
        chk("pp_count_start", 32'(dut.count), 32'd3);
        for (int k = 0; k < 10; k++) begin
            step(2'b11, (k % 2 == 0) ? 2'b01 : 2'b10, "pp_grant");
            chk("pp_count", 32'(dut.count), 32'd3);
        end
        drain("pp_drain");

        // Flush with 3 in flight
        rsp_ready = 2'b00;
        step(2'b11, 2'b01, "fl_i0");
        step(2'b11, 2'b10, "fl_i1");
        step(2'b11, 2'b01, "fl_i2");
        chk("fl_count", 32'(dut.count), 32'd3);
        flush_req = 1'b1;
        rsp_ready = 2'b11;
        exp_q.delete();
        @(negedge clk_core);
        chk("fl_alu_valid", 32'(alu_valid), 32'd0);
        chk("fl_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("fl_out_ready", 32'(alu_out_ready), 32'd0);
        chk("fl_alu_flush_req", 32'(alu_flush_req), 32'd1);
        chk("fl_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk_core); #1;
        @(negedge clk_core);
        chk("fl_ack_pre", 32'(flush_ack), 32'd0);
        @(posedge clk_core); #1;
        chk("fl_ack", 32'(flush_ack), 32'd1);
        chk("fl_count_clr", 32'(dut.count), 32'd0);
        flush_req = 1'b0;
        step(2'b11, 2'b00, "fl_leave");
        chk("fl_prio", 32'(dut.prio), 32'd0);
        chk("fl_ack_fall", 32'(flush_ack), 32'd0);
        step(2'b11, 2'b01, "fl_first");
        drain("fl_drain");

        // Reset mid-operation with 2 in flight
        rsp_ready = 2'b00;
        step(2'b11, 2'b10, "rs_i0");
        step(2'b11, 2'b01, "rs_i1");
        req_valid = '0;
        chk("rs_count_pre", 32'(dut.count), 32'd2);
        rst_core = 1'b0;
        #1;
        chk("rs_count", 32'(dut.count), 32'd0);
        chk("rs_flush_ack", 32'(flush_ack), 32'd0);
        chk("rs_out_ready", 32'(alu_out_ready), 32'd0);
        exp_q.delete();
        @(posedge clk_core); #1;
        rst_core = 1'b1;
        @(negedge clk_core);
        chk("rs_out_ready_post", 32'(alu_out_ready), 32'd0);
        chk("rs_rsp_valid_post", 32'(rsp_valid), 32'd0);
        @(posedge clk_core); #1;
        rsp_ready = 2'b11;
        step(2'b11, 2'b01, "rs_first");
        drain("rs_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hsv_core_alu_arbiter.md
# hsv_core_alu_arbiter

Shares one `hsv_core_alu` instance between `N_REQ` issue requesters. Round-robin arbitration selects one `alu_data_t` per cycle. A requester-ID FIFO records issue order so in-order ALU results are routed back to the requester that issued them. The block sits between the issue stage(s) and the ALU, and forwards the core flush handshake to the ALU.

## Interface
Parameters:
- `N_REQ`, 2 — number of requesters, ≥ 2.
- `TAG_DEPTH`, 4 — ID FIFO depth. It must be ≥ the number of in-flight ALU results: 2 pipeline stages + 2 skid entries.

Ports:
- `clk_core` in 1 — core clock.
- `rst_core` in 1 — asynchronous, active-low reset.
- `flush_req` in 1 — core flush request.
- `flush_ack` out 1 — flush complete.
- `req_data` in `N_REQ`×`alu_data_t` — per-requester ALU operation.
- `req_valid` in `N_REQ` — per-requester valid.
- `req_ready` out `N_REQ` — per-requester accept.
- `alu_data` out `alu_data_t` — to ALU sink.
- `alu_valid` out 1 — to ALU sink.
- `alu_ready` in 1 — from ALU sink.
- `alu_flush_req` out 1 — flush request to ALU.
- `alu_flush_ack` in 1 — flush acknowledge from ALU.
- `alu_commit_data` in `commit_data_t` — from ALU source.
- `alu_out_valid` in 1 — from ALU source.
- `alu_out_ready` out 1 — to ALU source.
- `rsp_data` out `commit_data_t` — result, broadcast to all requesters.
- `rsp_valid` out `N_REQ` — one-hot per-requester result valid.
- `rsp_ready` in `N_REQ` — per-requester result accept.

## Operation
- **State machine:** states `RUN` and `FLUSH`.
  - `RUN`→`FLUSH` when `flush_req`=1.
  - `FLUSH`→`RUN` when `flush_req`=0.
- **Round-robin pointer `prio`:**
  - Grant = first `i` with `req_valid[i]`, searching `prio`, `prio+1`, … mod `N_REQ`.
  - After an issue handshake to requester `g`: `prio` ← (`g`+1) mod `N_REQ`.
  - With no handshake, `prio` holds.
- **Issue enable:** `issue_ok` = state==`RUN` & ~`flush_req` & `count` < `TAG_DEPTH`.
  - `alu_valid` = `issue_ok` & |`req_valid`.
  - `alu_data` = `req_data[g]`.
  - `req_ready[i]` = `issue_ok` & `alu_ready` & (`i`==`g`).
  - Only one `req_ready` bit may be high per cycle.
- **ID FIFO:** entries are `$clog2(N_REQ)` bits; `count` is `$clog2(TAG_DEPTH+1)` bits.
  - Push `g` on `alu_valid`&`alu_ready`.
  - Pop on `alu_out_valid`&`alu_out_ready`.
  - Simultaneous push and pop: `count` unchanged; read and write pointers both advance and wrap mod `TAG_DEPTH`.
  - Full is evaluated on registered `count`. A pop in the same cycle does not permit a push when `count`==`TAG_DEPTH`.
- **Result routing:** `h` = FIFO head.
  - `rsp_valid[i]` = `alu_out_valid` & `count`≠0 & ~`flush_req` & (`i`==`h`).
  - `alu_out_ready` = `rsp_ready[h]` & `count`≠0 & ~`flush_req`.
  - `rsp_data` = `alu_commit_data` unconditionally.
  - `alu_out_valid` with `count`==0 is a protocol error: the result is not accepted and a simulation assertion fires.
- **Flush:**
  - `alu_flush_req` = `flush_req`.
  - Every cycle `flush_req`=1: `count`, pointers and `prio` are cleared to 0; issue and response are blocked.
  - `flush_ack` is registered and equals `flush_req` & `alu_flush_ack`.

## Timing
- **Reset:**
  - Asynchronous on `rst_core`=0.
  - state=`RUN`, `count`=0, pointers=0, `prio`=0, `flush_ack`=0.
  - Combinational outputs resolve to: `req_ready`=0 unless `req_valid`, `alu_valid`=0, `rsp_valid`=0, `alu_out_ready`=0.
  - Reset mid-operation discards all in-flight IDs.
- **Latency:**
  - Issue path is combinational, 0 cycles from `req_valid` to `alu_valid`.
  - Response routing is combinational, 0 cycles.
  - FIFO and `prio` update on the clock edge after a handshake.
- **Throughput:** one issue and one response per cycle.
- **Flush latency:** `flush_ack` rises 1 cycle after `flush_req`&`alu_flush_ack`, and falls 1 cycle after `flush_req` drops.
- **Handshakes:** standard valid/ready. Requesters must hold `req_data` stable while `req_valid`=1 and not accepted. The arbiter may change the grant between cycles.
- **Back-pressure:** `rsp_ready[h]`=0 stalls the ALU output and therefore eventually the ALU input. The full FIFO independently stalls issue.

## Structure
- `hsv_core_pkg` additions:
  - `typedef alu_req_id` — `$clog2(N_REQ)` bits, with `N_REQ` fixed by a package constant `ALU_N_REQ`=2.
  - constant `ALU_TAG_DEPTH`=4.
- Sub-module `hsv_core_alu_id_fifo`: synchronous FIFO with push, pop, clear, `count` and head outputs, and the same asynchronous reset.
- The top module holds the state machine, the round-robin selector and the routing muxes.

## Test plan
- **Round-robin under contention:** `req_valid`=2'b11 continuously, `alu_ready`=1 → grants alternate 0,1,0,1. Results return with `rsp_valid` 01,10,01,10 in issue order.
- **Single requester:** only `req_valid[1]`=1 → 1 issued every cycle. After it drops, `req_valid[0]`=1 is granted in the same cycle.
- **FIFO full:** `rsp_ready`=0 and `alu_out_valid` held → after 4 issues `count`=4 and `req_ready`=0. A single response pop frees exactly one issue slot on the next cycle.
- **Simultaneous push and pop at `count`=3:** `count` stays 3, head advances, and the ID order is preserved across pointer wrap after 10 transactions.
- **Flush mid-stream with 3 in flight:**
  - `flush_req`=1 → `alu_valid`, `rsp_valid` and `alu_out_ready` drop the same cycle; `alu_flush_req`=1.
  - `alu_flush_ack`=1 at cycle t → `flush_ack`=1 at t+1.
  - After `flush_req` drops, `count`=0, `prio`=0, and the first grant goes to requester 0.
- **Reset mid-operation:** `rst_core` low while `count`=2 → `count`=0 and `flush_ack`=0 immediately. A stray `alu_out_valid` then triggers the assertion and `alu_out_ready`=0.
